// File: rtl/gru_window_scheduler_if.sv
// Stream-in / prediction-out handshake bundle for gru_window_scheduler.
interface gru_window_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // Upstream/downstream side: drives feature words, accepts predictions
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    // Scheduler side: consumes feature words, emits predictions
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/gru_window_scheduler.sv
// Sliding-window scheduler feeding GRU_Model: builds a window of timesteps,
// launches an inference every STRIDE new timesteps and emits each prediction.
module gru_window_scheduler #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned INPUT_FEATURES  = 3,
    parameter int unsigned SEQUENCE_LENGTH = 3,
    parameter int unsigned STRIDE          = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  i_enable,
    input  logic                                                  i_flush,
    gru_window_scheduler_if.slave                                 bus,
    output logic [SEQUENCE_LENGTH*INPUT_FEATURES*DATA_WIDTH-1:0]  o_sequence_flat,
    output logic                                                  o_gru_start,
    input  logic                                                  i_gru_done,
    input  logic [DATA_WIDTH-1:0]                                 i_gru_prediction,
    output logic                                                  o_busy,
    output logic                                                  o_timeout_err,
    output logic [15:0]                                           o_infer_count
);
    localparam int unsigned WORDS  = SEQUENCE_LENGTH * INPUT_FEATURES;
    localparam int unsigned WIN_W  = WORDS * DATA_WIDTH;
    localparam int unsigned TS_W   = INPUT_FEATURES * DATA_WIDTH;
    localparam int unsigned TOP    = WORDS - INPUT_FEATURES;
    localparam int unsigned FEAT_W = (INPUT_FEATURES > 1) ? $clog2(INPUT_FEATURES) : 1;
    localparam int unsigned CNT_W  = $clog2(SEQUENCE_LENGTH + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        EMIT      = 2'd3
    } state_t;

    state_t                  state;
    logic [WIN_W-1:0]        window_q;
    logic [TS_W-1:0]         stage_q;
    logic [FEAT_W-1:0]       feat_cnt;
    logic [CNT_W-1:0]        fill_cnt;
    logic [CNT_W-1:0]        new_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_valid_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    terr_q;
    logic [15:0]             infer_cnt_q;

    logic                    s_ready_c;
    logic                    accept_c;
    logic                    ts_done_c;
    logic                    launch_c;
    logic [CNT_W-1:0]        fill_next_c;
    logic [CNT_W-1:0]        new_next_c;
    logic [TS_W-1:0]         new_ts_c;

    // Input acceptance, timestep completion and launch decision
    always_comb begin
        s_ready_c   = (state == FILL) && i_enable && !i_flush && !rst;
        accept_c    = bus.s_valid && s_ready_c;
        ts_done_c   = accept_c && (feat_cnt == FEAT_W'(INPUT_FEATURES - 1));
        fill_next_c = (fill_cnt == CNT_W'(SEQUENCE_LENGTH)) ? fill_cnt : fill_cnt + CNT_W'(1);
        new_next_c  = (new_cnt == CNT_W'(SEQUENCE_LENGTH)) ? new_cnt : new_cnt + CNT_W'(1);
        launch_c    = ts_done_c && (fill_next_c == CNT_W'(SEQUENCE_LENGTH))
                      && (new_next_c >= CNT_W'(STRIDE));
        new_ts_c    = stage_q;
        new_ts_c[(INPUT_FEATURES-1)*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
    end

    // Staging register and sliding window; newest timestep enters at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            stage_q  <= '0;
        end else if (i_flush) begin
            window_q <= '0;
            stage_q  <= '0;
        end else if (accept_c) begin
            if (ts_done_c) begin
                window_q <= (window_q >> TS_W) | (WIN_W'(new_ts_c) << (TOP * DATA_WIDTH));
            end else begin
                stage_q[feat_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
            end
        end
    end

    // Scheduler FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            feat_cnt    <= '0;
            fill_cnt    <= '0;
            new_cnt     <= '0;
            tmo_cnt     <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            infer_cnt_q <= '0;
        end else if (i_flush) begin
            state     <= FILL;
            feat_cnt  <= '0;
            fill_cnt  <= '0;
            new_cnt   <= '0;
            tmo_cnt   <= '0;
            m_valid_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept_c) begin
                        if (ts_done_c) begin
                            feat_cnt <= '0;
                            fill_cnt <= fill_next_c;
                            if (launch_c) begin
                                new_cnt <= '0;
                                state   <= LAUNCH;
                                busy_q  <= 1'b1;
                            end else begin
                                new_cnt <= new_next_c;
                            end
                        end else begin
                            feat_cnt <= feat_cnt + FEAT_W'(1);
                        end
                    end
                end
                LAUNCH: begin
                    // wait for the previous done to drop before starting again
                    if (!i_gru_done) begin
                        start_q <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_gru_done) begin
                        m_data_q  <= i_gru_prediction;
                        m_valid_q <= 1'b1;
                        start_q   <= 1'b0;
                        state     <= EMIT;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        start_q <= 1'b0;
                        terr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                EMIT: begin
                    if (m_valid_q && bus.m_ready) begin
                        m_valid_q   <= 1'b0;
                        infer_cnt_q <= infer_cnt_q + 16'd1;
                        busy_q      <= 1'b0;
                        state       <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Output wiring
    assign bus.s_ready     = s_ready_c;
    assign bus.m_data      = m_data_q;
    assign bus.m_valid     = m_valid_q;
    assign o_sequence_flat = window_q;
    assign o_gru_start     = start_q;
    assign o_busy          = busy_q;
    assign o_timeout_err   = terr_q;
    assign o_infer_count   = infer_cnt_q;
endmodule

// File: tb/tb_gru_window_scheduler.sv
// Directed bench for gru_window_scheduler: stride-1 instance (a) and stride-3 instance (b).
module tb_gru_window_scheduler;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 9;
    localparam int unsigned FW = NW * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    gru_window_scheduler_if #(.DATA_WIDTH(DW)) ifa ();
    gru_window_scheduler_if #(.DATA_WIDTH(DW)) ifb ();

    logic          en_a, flush_a, done_a, start_a, busy_a, terr_a;
    logic [DW-1:0] pred_a;
    logic [FW-1:0] flat_a;
    logic [15:0]   cnt_a;
    logic          en_b, flush_b, done_b, start_b, busy_b, terr_b;
    logic [DW-1:0] pred_b;
    logic [FW-1:0] flat_b;
    logic [15:0]   cnt_b;

    gru_window_scheduler #(
        .DATA_WIDTH(DW), .INPUT_FEATURES(3), .SEQUENCE_LENGTH(3),
        .STRIDE(1), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(rst), .i_enable(en_a), .i_flush(flush_a), .bus(ifa.slave),
        .o_sequence_flat(flat_a), .o_gru_start(start_a), .i_gru_done(done_a),
        .i_gru_prediction(pred_a), .o_busy(busy_a), .o_timeout_err(terr_a),
        .o_infer_count(cnt_a)
    );

    gru_window_scheduler #(
        .DATA_WIDTH(DW), .INPUT_FEATURES(3), .SEQUENCE_LENGTH(3),
        .STRIDE(3), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .i_enable(en_b), .i_flush(flush_b), .bus(ifb.slave),
        .o_sequence_flat(flat_b), .o_gru_start(start_b), .i_gru_done(done_b),
        .i_gru_prediction(pred_b), .o_busy(busy_b), .o_timeout_err(terr_b),
        .o_infer_count(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [FW-1:0] f, input int i);
        return f[i*DW +: DW];
    endfunction

    // base==0 expects an all-zero window, otherwise words base..base+8
    task automatic check_window(input string tag, input logic [FW-1:0] f, input int base);
        for (int i = 0; i < NW; i++)
            check(tag, 64'(word_of(f, i)), (base == 0) ? 64'd0 : 64'(base + i));
    endtask

    task automatic send_a(input int w);
        int n = 0;
        @(negedge clk);
        ifa.s_data  = DW'(w);
        ifa.s_valid = 1'b1;
        while (!ifa.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_a_ready", 64'(ifa.s_ready), 64'd1);
        @(posedge clk);
        #1;
        ifa.s_valid = 1'b0;
    endtask

    task automatic send_b(input int w);
        int n = 0;
        @(negedge clk);
        ifb.s_data  = DW'(w);
        ifb.s_valid = 1'b1;
        while (!ifb.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_b_ready", 64'(ifb.s_ready), 64'd1);
        @(posedge clk);
        #1;
        ifb.s_valid = 1'b0;
    endtask

    task automatic wait_start_a();
        int n = 0;
        while (!start_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 64'(start_a), 64'd1);
    endtask

    // Pulse done for one cycle with the given prediction; m_ready held at mr
    task automatic respond_a(input logic [DW-1:0] pred, input logic mr);
        @(negedge clk);
        done_a      = 1'b1;
        pred_a      = pred;
        ifa.m_ready = mr;
        @(posedge clk);
        #1;
        check("emit_valid", 64'(ifa.m_valid), 64'd1);
        check("emit_data", 64'(ifa.m_data), 64'(pred));
        check("emit_start_low", 64'(start_a), 64'd0);
        @(negedge clk);
        done_a = 1'b0;
    endtask

    // Automatic GRU model for instance b: done one cycle after start, logs windows
    logic          b_active = 1'b0;
    logic          prev_start_b = 1'b0;
    int            nstarts_b = 0;
    logic [FW-1:0] win_log [4];

    always @(negedge clk) begin
        if (b_active) begin
            if (start_b && !prev_start_b) begin
                if (nstarts_b < 4) win_log[nstarts_b] = flat_b;
                nstarts_b++;
            end
            prev_start_b = start_b;
            done_b       = start_b;
            pred_b       = 32'hB000 + DW'(nstarts_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst     = 1'b1;
        en_a    = 1'b1;  flush_a = 1'b0; done_a = 1'b0; pred_a = '0;
        en_b    = 1'b1;  flush_b = 1'b0; done_b = 1'b0; pred_b = '0;
        ifa.s_data = '0; ifa.s_valid = 1'b0; ifa.m_ready = 1'b0;
        ifb.s_data = '0; ifb.s_valid = 1'b0; ifb.m_ready = 1'b1;

        // Reset state
        #12;
        check("rst_s_ready", 64'(ifa.s_ready), 64'd0);
        check("rst_start", 64'(start_a), 64'd0);
        check("rst_m_valid", 64'(ifa.m_valid), 64'd0);
        check("rst_count", 64'(cnt_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check_window("rst_window", flat_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // Enable gates s_ready in FILL
        @(negedge clk);
        en_a = 1'b0;
        #1 check("en0_s_ready", 64'(ifa.s_ready), 64'd0);
        en_a = 1'b1;
        #1 check("en1_s_ready", 64'(ifa.s_ready), 64'd1);

        // Basic fill and launch, 2-cycle latency to start
        for (int w = 1; w <= 9; w++) send_a(w);
        check("lat_start_c1", 64'(start_a), 64'd0);
        check("lat_busy_c1", 64'(busy_a), 64'd1);
        check_window("win_basic", flat_a, 1);
        @(posedge clk);
        #1 check("lat_start_c2", 64'(start_a), 64'd1);
        respond_a(32'h0000ABCD, 1'b1);
        @(posedge clk);
        #1;
        check("basic_m_valid_drop", 64'(ifa.m_valid), 64'd0);
        check("basic_count", 64'(cnt_a), 64'd1);

        // Sliding window
        for (int w = 10; w <= 12; w++) send_a(w);
        check_window("win_slide", flat_a, 4);
        wait_start_a();
        respond_a(32'h00001234, 1'b1);
        @(posedge clk);
        #1 check("slide_count", 64'(cnt_a), 64'd2);

        // Output backpressure
        for (int w = 13; w <= 15; w++) send_a(w);
        wait_start_a();
        respond_a(32'h00005555, 1'b0);
        @(negedge clk);
        ifa.s_valid = 1'b1;
        ifa.s_data  = 32'h0000DEAD;
        for (int i = 0; i < 20; i++) begin
            check("bp_m_valid", 64'(ifa.m_valid), 64'd1);
            check("bp_m_data", 64'(ifa.m_data), 64'h5555);
            check("bp_s_ready", 64'(ifa.s_ready), 64'd0);
            @(negedge clk);
        end
        ifa.s_valid = 1'b0;
        ifa.m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(ifa.m_valid), 64'd0);
        check("bp_count", 64'(cnt_a), 64'd3);
        @(posedge clk);
        #1 check("bp_single_accept", 64'(cnt_a), 64'd3);

        // Timeout: done never arrives
        for (int w = 16; w <= 18; w++) send_a(w);
        wait_start_a();
        n = 0;
        while (start_a && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cycles", 64'(n), 64'd16);
        check("tmo_err", 64'(terr_a), 64'd1);
        check("tmo_m_valid", 64'(ifa.m_valid), 64'd0);
        check("tmo_s_ready", 64'(ifa.s_ready), 64'd1);
        check("tmo_busy", 64'(busy_a), 64'd0);
        check_window("tmo_window_kept", flat_a, 10);

        // Flush clears sticky timeout error
        @(negedge clk);
        flush_a = 1'b1;
        #1 check("flush_s_ready", 64'(ifa.s_ready), 64'd0);
        @(posedge clk);
        #1 check("flush_terr", 64'(terr_a), 64'd0);
        @(negedge clk);
        flush_a = 1'b0;

        // Flush during WAIT_DONE abandons inference and empties the window
        for (int w = 19; w <= 27; w++) send_a(w);
        wait_start_a();
        @(negedge clk);
        flush_a = 1'b1;
        @(posedge clk);
        #1;
        check("wflush_start", 64'(start_a), 64'd0);
        check("wflush_busy", 64'(busy_a), 64'd0);
        check_window("wflush_window", flat_a, 0);
        @(negedge clk);
        flush_a = 1'b0;
        for (int w = 28; w <= 35; w++) send_a(w);
        repeat (3) @(negedge clk);
        check("refill_no_start", 64'(start_a), 64'd0);
        check("refill_not_busy", 64'(busy_a), 64'd0);
        send_a(36);
        check("refill_start_c1", 64'(start_a), 64'd0);
        @(posedge clk);
        #1 check("refill_start_c2", 64'(start_a), 64'd1);
        check_window("refill_window", flat_a, 28);

        // Asynchronous reset in EMIT
        respond_a(32'h00000077, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(ifa.m_valid), 64'd0);
        check("arst_m_data", 64'(ifa.m_data), 64'd0);
        check("arst_start", 64'(start_a), 64'd0);
        check("arst_busy", 64'(busy_a), 64'd0);
        check("arst_count", 64'(cnt_a), 64'd0);
        check("arst_s_ready", 64'(ifa.s_ready), 64'd0);
        check_window("arst_window", flat_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // Stride 3: two non-overlapping windows from 18 words
        b_active = 1'b1;
        for (int w = 1; w <= 18; w++) send_b(w);
        repeat (20) @(negedge clk);
        check("stride_starts", 64'(nstarts_b), 64'd2);
        check_window("stride_win0", win_log[0], 1);
        check_window("stride_win1", win_log[1], 10);
        check("stride_count", 64'(cnt_b), 64'd2);
        check("stride_m_data", 64'(ifb.m_data), 64'hB002);
        check("stride_busy", 64'(busy_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gru_window_scheduler.md
Name: gru_window_scheduler

Overview:
- Sequences the GRU_Model datapath for streaming equalisation.
- Collects incoming feature words into a sliding window of SEQUENCE_LENGTH timesteps and launches one inference every STRIDE new timesteps, using a level start / done handshake.
- Captures each prediction and presents it on a valid/ready output.
- Sits between the sample front-end and GRU_Model, replacing one-shot serial loading with continuous scheduling.

Parameters:
- DATA_WIDTH, 32, width of every feature word and of the prediction.
- INPUT_FEATURES, 3, words per timestep.
- SEQUENCE_LENGTH, 3, timesteps per window.
- STRIDE, 1, new timesteps between inferences; legal range 1..SEQUENCE_LENGTH.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for done before aborting.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_enable, input, 1, permits acceptance of input words.
- i_flush, input, 1, synchronous clear of window, counters and pending output.
- s_data, input, DATA_WIDTH, feature word.
- s_valid, input, 1, s_data valid.
- s_ready, output, 1, word accepted when s_valid && s_ready.
- o_sequence_flat, output, SEQUENCE_LENGTH*INPUT_FEATURES*DATA_WIDTH, window to GRU_Model.
- o_gru_start, output, 1, start level to GRU_Model.
- i_gru_done, input, 1, GRU_Model done.
- i_gru_prediction, input, DATA_WIDTH, GRU_Model result.
- m_data, output, DATA_WIDTH, captured prediction.
- m_valid, output, 1, m_data valid.
- m_ready, input, 1, downstream accept.
- o_busy, output, 1, high in LAUNCH, WAIT_DONE or EMIT.
- o_timeout_err, output, 1, sticky; set on timeout, cleared only by rst or i_flush.
- o_infer_count, output, 16, completed inferences delivered on m_*; wraps at 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=FILL.
  - All outputs 0, including o_sequence_flat, o_gru_start, m_valid, s_ready and o_infer_count.
  - Counters and staging register cleared.
- Window layout:
  - Word w = t*INPUT_FEATURES + f sits at o_sequence_flat[w*DATA_WIDTH +: DATA_WIDTH].
  - t=0 is the oldest timestep; feature f is in arrival order.
- FILL:
  - s_ready = i_enable (combinational from state and i_enable).
  - Each accepted word is stored in the staging register at feat_cnt, and feat_cnt increments.
  - On the accepted word with feat_cnt==INPUT_FEATURES-1 (timestep completes), in the same edge:
    - Window shifts down by INPUT_FEATURES words; the oldest timestep is dropped.
    - Staging words plus the current s_data are written to t=SEQUENCE_LENGTH-1.
    - feat_cnt returns to 0.
    - fill_cnt increments, saturating at SEQUENCE_LENGTH.
    - new_cnt increments.
  - If after that update fill_cnt==SEQUENCE_LENGTH and new_cnt>=STRIDE: new_cnt is cleared and the next state is LAUNCH.
- LAUNCH:
  - s_ready=0.
  - If i_gru_done==0: o_gru_start goes to 1, timeout counter cleared, go to WAIT_DONE.
  - Otherwise stay in LAUNCH; this guarantees the previous done has dropped before a new start.
- WAIT_DONE:
  - o_gru_start held at 1. o_sequence_flat is frozen: s_ready=0 and no shift occurs.
  - On i_gru_done=1: capture i_gru_prediction into m_data, o_gru_start goes to 0, m_valid goes to 1, go to EMIT.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without done: o_gru_start goes to 0, o_timeout_err goes to 1, no output is produced, go to FILL. The window is kept.
  - If done arrives on the same cycle the timeout would fire, done wins.
- EMIT:
  - s_ready=0 and o_gru_start=0.
  - On m_valid && m_ready: m_valid goes to 0, o_infer_count increments, go to FILL.
  - m_data is stable while m_valid=1.
- Start-to-done latency is set by GRU_Model. Last accepted word to o_gru_start=1 is 2 cycles (FILL to LAUNCH edge, then LAUNCH edge).
- i_flush=1 has priority over every state, takes effect at the next edge, and does the following:
  - Clears window, staging, feat_cnt, fill_cnt, new_cnt and o_timeout_err.
  - Drops m_valid and o_gru_start; any in-flight inference is abandoned.
  - Goes to FILL.
  - s_ready=0 during the flush cycle.
- i_enable=0:
  - Only gates s_ready in FILL.
  - A partial timestep is retained.
  - An inference in progress completes and emits normally.
- STRIDE=SEQUENCE_LENGTH gives non-overlapping windows. After the first inference, fill_cnt stays at SEQUENCE_LENGTH, so each subsequent inference needs exactly STRIDE new timesteps.

Test Plan:
- Basic fill and launch. Setup: IF=3, SL=3, STRIDE=1. Stimulus: feed words 1..9 back-to-back. Required response:
  - Window words 0..8 = 1..9.
  - o_gru_start rises 2 cycles after word 9.
  - Done pulse with prediction 0x0000ABCD and m_ready=1 gives m_data=0x0000ABCD, m_valid for 1 cycle, o_infer_count=1.
- Sliding window: continue from the basic test with words 10,11,12. Required response: window words = 4..12, a second start is issued, o_infer_count=2 after accept.
- Stride: STRIDE=3, feed 18 words. Required response: exactly two inferences, with windows 1..9 then 10..18.
- Output backpressure: hold m_ready=0 for 20 cycles after done. Required response: m_valid stays 1, m_data unchanged, s_ready=0 throughout; release gives one accept.
- Timeout: TIMEOUT_CYCLES=16, never assert done. Required response: o_gru_start falls after 16 cycles, o_timeout_err=1, m_valid stays 0, s_ready returns to 1; a later i_flush clears o_timeout_err.
- Flush and reset mid-operation:
  - Pulse i_flush during WAIT_DONE: o_gru_start=0 next cycle, window is 0, 9 new words are needed before the next start.
  - Assert rst asynchronously in EMIT: all outputs 0 immediately.
